// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store front end for a word-wide data memory.
// Sub-word stores use read-modify-write. Loads are sign- or zero-extended.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When it is defined, misaligned
// half/word requests are rejected with rsp_err. When it is not defined, the low
// address bits are ignored as needed.
module load_store_unit #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

  state_t      state_reg, state_next;
  logic        we_reg, uns_reg, err_reg;
  logic [1:0]  size_reg, off_reg;
  logic [31:0] wdata_reg, addr_reg, rdata_reg, merge_reg;

  logic        out_of_range, misaligned, reject;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_value, merged;
  logic [3:0]  byte_en;

  assign out_of_range = ({1'b0, req_addr} >= ADDR_LIMIT);
`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif
  assign reject = out_of_range || misaligned;

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;
  assign mem_addr  = addr_reg;

  // Lane extraction. Half selection ignores addr[0], so a misaligned half
  // (trap disabled) returns the half that contains it.
  assign byte_lane = mem_rdata[{off_reg, 3'b000} +: 8];
  assign half_lane = mem_rdata[{off_reg[1], 4'b0000} +: 16];

  // Extend the selected lane according to size and signedness.
  always_comb begin
    load_value = mem_rdata;
    case (size_reg)
      2'b00:   load_value = {{24{~uns_reg & byte_lane[7]}}, byte_lane};
      2'b01:   load_value = {{16{~uns_reg & half_lane[15]}}, half_lane};
      default: load_value = mem_rdata;
    endcase
  end

  // Byte lanes touched by a sub-word store.
  always_comb begin
    byte_en = 4'b1111;
    case (size_reg)
      2'b00:   byte_en = 4'b0001 << off_reg;
      2'b01:   byte_en = off_reg[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  // Replace the target lanes of the fetched word with store data.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign merged[8*gi +: 8] = byte_en[gi]
        ? ((size_reg == 2'b00) ? wdata_reg[7:0] : wdata_reg[8*(gi%2) +: 8])
        : mem_rdata[8*gi +: 8];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and memory-port control.
  always_comb begin
    state_next = state_reg;
    mem_write  = 1'b0;
    mem_wdata  = 32'd0;
    case (state_reg)
      IDLE: begin
        if (req_valid) state_next = reject ? RESP : ACCESS;
      end
      ACCESS: begin
        if (we_reg && !size_reg[1]) begin
          state_next = WRITE;
        end else begin
          state_next = RESP;
          if (we_reg) begin
            mem_write = 1'b1;
            mem_wdata = wdata_reg;
          end
        end
      end
      WRITE: begin
        mem_write  = 1'b1;
        mem_wdata  = merge_reg;
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, load result and RMW word registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg    <= 1'b0;
      uns_reg   <= 1'b0;
      err_reg   <= 1'b0;
      size_reg  <= 2'b00;
      off_reg   <= 2'b00;
      wdata_reg <= 32'd0;
      addr_reg  <= 32'd0;
      rdata_reg <= 32'd0;
      merge_reg <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            we_reg    <= req_we;
            uns_reg   <= req_unsigned;
            size_reg  <= req_size;
            off_reg   <= req_addr[1:0];
            wdata_reg <= req_wdata;
            addr_reg  <= {req_addr[31:2], 2'b00};
            rdata_reg <= 32'd0;
            err_reg   <= reject;
          end
        end
        ACCESS: begin
          if (!we_reg)             rdata_reg <= load_value;
          else if (!size_reg[1])   merge_reg <= merged;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed plus random requests, scoreboard
// checked against an arithmetic reference model. Honors LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  load_store_unit #(.MEM_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Attached data memory: combinational read, word write on clock edge.
  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[11:2]] <= mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          writes;
    int          acc;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_mis = 0;
  int hold_cnt = 0;
  int wr_cnt = 0;
  bit first_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference model: computes the response from the access rules directly.
  function automatic exp_t model(input logic we, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int nb, off;
    bit mis, oor;
    logic [31:0] mask, w, v;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off = a % 4;
    mis = (off % nb) != 0;
    oor = (a >= 32'd4096);
    off = off - (off % nb);
`ifdef LSU_MISALIGN_TRAP_EN
    e.err = oor || mis;
`else
    e.err = oor;
`endif
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
    e.rdata = 32'd0;
    e.writes = 0;
    if (e.err) begin
      e.lat = 1;
    end else begin
      w = ref_mem[a / 4];
      if (we) begin
        ref_mem[a / 4] = (w & ~(mask << (8*off))) | ((wd & mask) << (8*off));
        e.writes = 1;
        e.lat = (nb < 4) ? 3 : 2;
      end else begin
        v = (w >> (8*off)) & mask;
        if (!uns && ((v & ~(mask >> 1)) != 0)) v = v | ~mask;
        e.rdata = v;
        e.lat = 2;
      end
    end
    return e;
  endfunction

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input bit push);
    int t = 0;
    exp_t e;
    @(negedge clk);
    while (!req_ready) begin
      @(negedge clk);
      t++;
      if (t > 200) begin
        chk("req_ready_timeout", 32'd0, 32'd1);
        return;
      end
    end
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    if (push) begin
      e = model(we, sz, uns, a, wd);
      e.acc = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    // Scramble fields after the accept edge; they must have no effect.
    req_valid = 1'b0; req_we = $urandom_range(0, 1); req_size = 2'($urandom);
    req_unsigned = $urandom_range(0, 1); req_addr = $urandom; req_wdata = $urandom;
  endtask

  // Response consumer: random backpressure, optional forced hold.
  always @(posedge clk) begin
    #2;
    if (hold_cnt > 0) begin
      rsp_ready = 1'b0;
      hold_cnt = hold_cnt - 1;
    end else begin
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: checks every cycle a response is presented, pops on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      wr_cnt = 0;
      first_seen = 0;
    end else begin
      if (mem_write) wr_cnt++;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
          chk("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
          chk("req_ready_in_resp", 32'(req_ready), 32'd0);
          if (!first_seen) begin
            first_seen = 1;
            chk("latency", 32'(cyc - exp_q[0].acc + 1), 32'(exp_q[0].lat));
            chk("mem_write_pulses", 32'(wr_cnt), 32'(exp_q[0].writes));
          end
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            first_seen = 0;
            wr_cnt = 0;
          end
        end
      end
    end
  end

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      t++;
      if (t > 1000) begin
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] saved;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_mem_write", 32'(mem_write), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases from the plan.
    issue(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 1);
    issue(0, 2'd2, 0, 32'h10, 32'h0, 1);
    issue(1, 2'd0, 0, 32'h11, 32'h55, 1);
    issue(0, 2'd2, 0, 32'h10, 32'h0, 1);
    issue(1, 2'd2, 0, 32'h10, 32'h80F07F81, 1);
    issue(0, 2'd0, 0, 32'h10, 32'h0, 1);
    issue(0, 2'd0, 1, 32'h10, 32'h0, 1);
    issue(0, 2'd1, 0, 32'h12, 32'h0, 1);
    issue(0, 2'd1, 0, 32'h13, 32'h0, 1);
    issue(0, 2'd2, 0, 32'h1000, 32'h0, 1);
    issue(1, 2'd2, 0, 32'h1000, 32'h12345678, 1);
    hold_cnt = 8;
    issue(0, 2'd2, 0, 32'h10, 32'h0, 1);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'h1000 + $urandom_range(0, 7);
        1:       a = $urandom;
        2:       a = 32'hFFC + $urandom_range(0, 3);
        default: a = $urandom_range(0, 63);
      endcase
      issue($urandom_range(0, 1), 2'($urandom), $urandom_range(0, 1), a, $urandom, 1);
    end
    drain();

    // Reset during the WRITE phase of a byte store.
    saved = ref_mem[8];
    issue(1, 2'd0, 0, 32'h21, 32'hA5, 0);
    @(posedge clk);
    #1;
    chk("rmw_write_phase", 32'(mem_write), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mem_unchanged", mem[8], saved);
    issue(0, 2'd2, 0, 32'h20, 32'h0, 1);
    drain();

    for (int i = 0; i < 1024; i++) begin
      if (mem[i] !== ref_mem[i] || i < 32) chk("mem_word", mem[i], ref_mem[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
